// File: rtl/mux8_sched_pkg.sv
// Shared types and constants for the eight-way round-robin mux scheduler.
package mux8_sched_pkg;

    localparam int NUM_REQ         = 8;
    localparam int SEL_W           = 3;
    localparam int DEFAULT_QUANTUM = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set bit of req searching from ptr upward, modulo 8.
module rr_pick8
    import mux8_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] k;

    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = ptr + SEL_W'(i);
            if (req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner of an 8:1 mux select; a grant lasts QUANTUM accepted transfers
// or until the owner drops its request, with zero-bubble handover.
module mux8_rr_scheduler
    import mux8_sched_pkg::*;
#(
    parameter int QUANTUM = DEFAULT_QUANTUM,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               rdy,
    output logic [SEL_W-1:0]   s,
    output logic [NUM_REQ-1:0] gnt,
    output logic               vld
);

    // Handshake: a transfer happens in any cycle where vld=1, rdy=1 and the
    // granted requester still holds req[s]; rdy=0 stalls without losing the grant.

    sched_state_e     state, state_nx;
    logic [SEL_W-1:0] ptr, ptr_nx;
    logic [SEL_W-1:0] s_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [NUM_REQ-1:0] gnt_nx;
    logic             vld_nx;

    logic             xfer;
    logic             last_xfer;
    logic             rel;
    logic [SEL_W-1:0] pick_ptr;
    logic             found;
    logic [SEL_W-1:0] idx;

    // On release the just-served index becomes lowest priority in the same edge.
    assign xfer      = (state == GRANT) && rdy && req[s];
    assign last_xfer = xfer && (cnt == CNT_W'(QUANTUM - 1));
    assign rel       = (state == GRANT) && (!req[s] || last_xfer);
    assign pick_ptr  = rel ? (s + SEL_W'(1)) : ptr;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (found),
        .idx   (idx)
    );

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        s_nx     = s;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = GRANT;
                    s_nx     = idx;
                    cnt_nx   = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_nx = pick_ptr;
                    cnt_nx = '0;
                    if (found) begin
                        s_nx = idx;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (xfer) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        vld_nx = (state_nx == GRANT);
        gnt_nx = vld_nx ? (NUM_REQ'(1) << s_nx) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            s     <= '0;
            gnt   <= '0;
            vld   <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
            s     <= s_nx;
            gnt   <= gnt_nx;
            vld   <= vld_nx;
        end
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed bench for mux8_rr_scheduler with hand-computed expected grants.
module tb_mux8_rr_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic [2:0] s;
    logic [7:0] gnt;
    logic       vld;

    int checks;
    int errors;

    mux8_rr_scheduler #(.QUANTUM(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .rdy (rdy),
        .s   (s),
        .gnt (gnt),
        .vld (vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        rdy = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic check_grant(input string tag, input int idx);
        check_eq({tag, "_vld"}, 32'(vld), 32'd1);
        check_eq({tag, "_s"},   32'(s),   32'(idx));
        check_eq({tag, "_gnt"}, 32'(gnt), 32'(8'(1) << idx));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req = '0;
        rdy = 1'b0;
        #2;
        check_eq("rst_vld", 32'(vld), 32'd0);
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_s",   32'(s),   32'd0);
        step();
        rst = 1'b0;

        // 1: async reset mid-grant, then first arbitration from index 0
        req = 8'h20;
        step();
        check_grant("t1_pre", 5);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t1_async_vld", 32'(vld), 32'd0);
        check_eq("t1_async_gnt", 32'(gnt), 32'd0);
        check_eq("t1_async_s",   32'(s),   32'd0);
        step();
        rst = 1'b0;
        req = 8'h81;
        step();
        check_grant("t1_first", 0);

        // 2: lone requester 3 is re-granted across quantum expiry
        do_reset();
        req = 8'h08;
        rdy = 1'b1;
        step();
        check_grant("t2_lat", 3);
        for (int i = 0; i < 8; i++) begin
            step();
            check_grant("t2_hold", 3);
        end

        // 3: all requesting, rotation 0..7,0 with 4 cycles each
        do_reset();
        req = 8'hFF;
        rdy = 1'b1;
        step();
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < 4; c++) begin
                check_grant("t3_rot", g % 8);
                step();
            end
        end

        // 4: stall with rdy=0 freezes the count
        do_reset();
        req = 8'h20;
        rdy = 1'b0;
        step();
        req = 8'h21;
        for (int i = 0; i < 10; i++) begin
            step();
            check_grant("t4_stall", 5);
        end
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_grant("t4_xfer", 5);
        end
        step();
        check_grant("t4_next", 0);

        // 5: owner drops request after two transfers
        do_reset();
        req = 8'h04;
        rdy = 1'b1;
        step();
        check_grant("t5_start", 2);
        req = 8'h44;
        step();
        check_grant("t5_x1", 2);
        step();
        check_grant("t5_x2", 2);
        req = 8'h40;
        step();
        check_grant("t5_drop", 6);

        // 6: wrap from 7 to 0 and back, then idle keeps s
        do_reset();
        req = 8'h80;
        rdy = 1'b1;
        step();
        check_grant("t6_start", 7);
        req = 8'h81;
        for (int i = 0; i < 3; i++) begin
            step();
            check_grant("t6_g7", 7);
        end
        step();
        check_grant("t6_wrap", 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_grant("t6_g0", 0);
        end
        step();
        check_grant("t6_back", 7);
        req = 8'h00;
        step();
        check_eq("t6_idle_vld", 32'(vld), 32'd0);
        check_eq("t6_idle_gnt", 32'(gnt), 32'd0);
        check_eq("t6_idle_s",   32'(s),   32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux8_rr_scheduler.md
# mux8_rr_scheduler

Round-robin scheduler that shares one 8:1 multiplexer output channel among eight requesters. It arbitrates the request vector and drives the mux select `s` with a registered value. A granted requester holds the channel for up to `QUANTUM` accepted transfers, or until it drops its request. The block sits directly in front of the eight-to-one multiplexer and is the only driver of its select lines.

## Interface
Parameters:
- `QUANTUM`, default 4: maximum accepted transfers per grant; legal range 1..15.
- `CNT_W`, default 4: transfer-counter width. Fixed; must hold `QUANTUM`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  8  request vector; bit i is requester i; level-sensitive.
- `rdy`  in  1  downstream accepts the mux output this cycle.
- `s`    out 3  mux select, registered; index of the current or last grant.
- `gnt`  out 8  one-hot grant, registered; all zero when idle.
- `vld`  out 1  grant active; mux output is meaningful.

## Operation
- States:
  - IDLE: no grant. `vld`=0, `gnt`=0, `s` holds the last granted index.
  - GRANT: `vld`=1, `gnt`=1<<`s`.
- Pointer `ptr` (3 bits) is the highest-priority index for the next arbitration.
  - The search order is `ptr`, `ptr`+1, …, `ptr`+7, modulo 8.
  - The winner is the first index in that order with `req` set.
- IDLE → GRANT: any `req` bit set. At the edge, load `s`=winner, set `gnt` and `vld`, and set `cnt`=0.
- Transfer: a cycle in GRANT with `rdy`=1 and `req[s]`=1. Each transfer increments `cnt`.
- Release occurs at the edge where either:
  - (a) `req[s]`=0, so no transfer happens that cycle; or
  - (b) a transfer brings `cnt` to `QUANTUM`.
- On release:
  - `ptr` ← `s`+1 mod 8. Arbitration then runs over `req` using the new order, in the same edge.
  - Winner exists: stay in GRANT with the new `s`/`gnt` and `cnt`=0. There is no idle bubble.
  - No winner: go to IDLE.
- The released requester has lowest priority in the re-arbitration. If it is the only requester, it is re-granted immediately after a quantum expiry.
- `rdy`=0 with `req[s]`=1: grant holds and `cnt` is frozen, indefinitely.
- Requests from non-granted requesters never preempt the current grant.
- Width rules:
  - `s`+1 wraps from 7 to 0.
  - `cnt` never exceeds `QUANTUM`; it resets to 0 on every new grant.

## Timing
- Reset values, applied immediately on `rst` assertion, mid-grant included: state IDLE, `s`=0, `gnt`=0, `vld`=0, `ptr`=0, `cnt`=0.
- After reset release, the first arbitration starts from index 0.
- Grant latency: a request first seen in IDLE in cycle t gives `gnt`/`vld` in cycle t+1.
- Handover latency: zero bubble. The release edge carries the next grant.
- All outputs are registered, with no combinational path from `req`/`rdy` to outputs.
- Invariants:
  - `gnt` is one-hot or zero.
  - `gnt`=0 exactly when `vld`=0.
  - When `vld`=1, `gnt`[`s`]=1.

## Structure
- Package `mux8_sched_pkg` contains:
  - State enum {IDLE, GRANT}.
  - Constants NUM_REQ=8 and SEL_W=3.
  - Default QUANTUM.
- Sub-module `rr_pick8`: combinational rotating-priority picker. Inputs are `req[7:0]` and `ptr[2:0]`; outputs are `found` and `idx[2:0]`.
- The top level holds the FSM, `ptr`, `cnt` and the output registers.

## Test plan
1. `rst` asserted mid-grant to requester 5 → in the same cycle `vld`=0, `gnt`=0x00, `s`=0. After release, `req`=0x81 → first grant is `s`=0.
2. `req`=0x08 held, `rdy`=1, `QUANTUM`=4:
   - `gnt`=0x08, `s`=3 one cycle after the request.
   - After 4 transfers, requester 3 is re-granted with `vld` staying 1 throughout.
3. `req`=0xFF, `rdy`=1 constant → grants rotate 0,1,…,7,0, each lasting exactly 4 cycles, with no bubble.
4. Grant to 5 with `req`=0x21 and `rdy`=0 for 10 cycles:
   - Grant stays 5 and `cnt` is frozen.
   - Once `rdy` returns, 4 transfers complete, then `gnt`=0x01.
5. Grant to 2 with `req`=0x44; requester 2 drops `req` after 2 transfers → next edge gives `gnt`=0x40, `s`=6.
6. Grant to 7 expires with `req`=0x81 → next grant `s`=0; the following grant returns to 7.
